keypad_scan_display: RTL and testbench
======================================

# keypad_scan_display

Parametrised successor to the 4x4 keypad-to-seven-segment top. Scans a 4x4 matrix keypad by column and debounces across whole sweeps. Emits one event per distinct press and shifts each key into a DIGITS-wide display buffer. The buffer is time-multiplexed onto common-anode seven-segment digits. It sits between the Pmod keypad header and the board display, and also exports key events to downstream logic.

## Interface
- DIGITS, 4: number of displayed digits and buffer depth (1..8)
- SCAN_DIV, 100000: clk cycles each column is driven before sampling
- DEBOUNCE_SWEEPS, 4: consecutive identical sweep results required (>=1)
- REFRESH_DIV, 100000: clk cycles each digit is lit
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row_n  in  4  keypad rows, active-low, externally pulled up
- col_n  out  4  keypad columns, one-hot active-low drive
- clr  in  1  synchronous clear of display buffer
- key_valid  out  1  one-cycle pulse per debounced key event
- key_code  out  4  hex value of last event, held between events
- anode  out  DIGITS  digit enables, one-hot active-low
- cathode  out  8  segments, active-low; [6:0]=gfedcba, [7]=dp (always 1)

## Operation
- **Key map** (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **Scan FSM states:** DRIVE(c) for c=0..3.
  - Column c is held low for SCAN_DIV cycles.
  - row_n is sampled on the last cycle of the window.
  - Then advance to c+1, wrapping 3->0. Wrapping 3->0 completes a sweep.
- **Sweep result:** first pressed key found, where lower column wins, then lower row within that column. If no row was low in any column, the result is NONE.
- **Debounce** (evaluated at sweep end):
  - If the result equals the previous result, increment the stable count (saturating). Otherwise load the count with 1 and record the new result.
  - The result is stable when the count reaches DEBOUNCE_SWEEPS.
- **Event:** fires when the stable result is a key and differs from the last reported result.
  - A stable NONE sets the reported result to NONE.
  - A held key therefore produces exactly one event.
  - A direct roll A->B produces an event for B.
- **Buffer shift on event:** digit[i] <= digit[i-1], digit[0] <= key_code, the oldest digit is dropped, and the digit's valid bit is set.
- **Clear:** clr clears all valid bits. clr has priority over a same-cycle event: the buffer stays empty, but key_valid still pulses with the code.
- **Display:** the refresh counter advances the digit index every REFRESH_DIV cycles, wrapping at DIGITS-1.
  - The current digit's anode bit is low.
  - cathode shows the hex glyph of the current digit, or 8'hFF if its valid bit is clear.
  - Glyphs: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.

## Timing
- **Reset values:**
  - col_n=4'b1110, key_valid=0, key_code=0
  - anode=~1 (digit 0 lit), cathode=8'hFF
  - all counters 0, all valid bits 0, previous result and reported result = NONE
- Reset acts immediately, including mid-sweep or mid-event. Scanning restarts at column 0 on the first edge after rst_n deasserts.
- col_n changes on the same edge that starts a new window, so rows settle for SCAN_DIV-1 cycles before sampling.
- One sweep takes 4*SCAN_DIV cycles.
- **Event latency:** key_valid is high in the cycle after the final sample of the DEBOUNCE_SWEEPS-th identical sweep.
  - key_code updates on the same edge.
  - The buffer updates on that edge; cathode reflects it in the next cycle whenever that digit is selected.
- anode and cathode are registered and change together; there are no cross-digit glitch cycles.

## Structure
- **keypad_pkg:**
  - key map constant
  - glyph table/function
  - NONE encoding (5-bit result: valid flag plus code)
- **Sub-module hex_to_seg7:** combinational nibble-to-cathode encoder, used in the display path.
- The scan/debounce FSM and the display multiplexer stay in keypad_scan_display.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SWEEPS=3, REFRESH_DIV=8, DIGITS=4.
- **Reset:** assert rst_n low mid-window -> immediately col_n=1110, anode=1110, cathode=FF, key_valid=0.
- **Held key:** hold '5' (row_n[1] low while col_n[1] low) for 10 sweeps -> one key_valid, key_code=5, at the end of sweep 3. digit0 shows cathode 92; other digits show FF.
- **Bounce:** toggle '5' pressed/released on alternate sweeps for 12 sweeps -> no key_valid.
- **Overflow:** press and release 1, 2, 3, A, 7, each for 4 sweeps -> five pulses. Digits 3..0 show A4, B0, 88, F8; '1' is dropped.
- **Roll and priority:** hold '3' then switch to 'D' without release -> events 3 then D. Press '1' and '0' together -> only '1' is reported.
- **Clear:** assert clr coincident with a key_valid pulse -> all anodes show FF thereafter, and key_valid still pulses.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: key map, seven-segment glyphs and scan result encoding shared by the keypad display
package keypad_pkg;
  typedef enum logic [1:0] {DRIVE0, DRIVE1, DRIVE2, DRIVE3} scan_t;
  typedef struct packed {
    logic valid;
    logic [3:0] code;
  } key_res_t;
  localparam key_res_t KEY_NONE = '{valid: 1'b0, code: 4'h0};
  // indexed by {row, col}
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };
  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  function automatic key_res_t key_at(input logic [1:0] row, input logic [1:0] col);
    return '{valid: 1'b1, code: KEY_MAP[{row, col}]};
  endfunction
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: nibble to active-low common-anode cathode pattern, blank when not enabled
module hex_to_seg7
  import keypad_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       en,
  output logic [7:0] seg
);
  assign seg = en ? GLYPH[hex] : 8'hFF;
endmodule

// File: rtl/keypad_scan_display.sv
// keypad_scan_display: 4x4 keypad column scanner with sweep debounce feeding a multiplexed hex display buffer
module keypad_scan_display
  import keypad_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_SWEEPS = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        row_n,
  output logic [3:0]        col_n,
  input  logic              clr,
  output logic              key_valid,
  output logic [3:0]        key_code,
  output logic [DIGITS-1:0] anode,
  output logic [7:0]        cathode
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  scan_t state, state_nx;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt, db_cnt_nx;
  logic win_end, sweep_end, stable, fire;
  key_res_t hit, sweep_now, sweep_acc, prev_res, reported;

  assign win_end = scan_cnt == SW'(SCAN_DIV - 1);
  assign sweep_end = win_end && state == DRIVE3;
  assign col_n = ~(4'b0001 << state);

  // sweep_acc holds the winner of earlier columns, so a lower column always wins
  always_comb begin
    hit = KEY_NONE;
    for (int r = 3; r >= 0; r--)
      if (!row_n[r]) hit = key_at(2'(r), state);
    state_nx = win_end ? scan_t'(state + 2'd1) : state;
    sweep_now = sweep_acc.valid ? sweep_acc : hit;
    db_cnt_nx = sweep_now != prev_res ? DW'(1) :
                db_cnt == DW'(DEBOUNCE_SWEEPS) ? db_cnt : db_cnt + 1'b1;
    stable = db_cnt_nx == DW'(DEBOUNCE_SWEEPS);
    fire = sweep_end && stable && sweep_now.valid && sweep_now != reported;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= DRIVE0;
    else state <= state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sweep_acc <= KEY_NONE;
      prev_res <= KEY_NONE;
      reported <= KEY_NONE;
      db_cnt <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
    end else begin
      scan_cnt <= win_end ? '0 : scan_cnt + 1'b1;
      key_valid <= fire;
      if (fire) key_code <= sweep_now.code;
      if (win_end) sweep_acc <= sweep_end ? KEY_NONE : sweep_now;
      if (sweep_end) begin
        prev_res <= sweep_now;
        db_cnt <= db_cnt_nx;
        if (stable) reported <= sweep_now;
      end
    end
  end

  logic [DIGITS-1:0][3:0] digits;
  logic [DIGITS-1:0] dig_valid;
  logic [RW-1:0] ref_cnt;
  logic [IW-1:0] idx, idx_nx;
  logic ref_end;
  logic [7:0] seg;

  assign ref_end = ref_cnt == RW'(REFRESH_DIV - 1);
  assign idx_nx = !ref_end ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;

  hex_to_seg7 u_seg (.hex(digits[idx_nx]), .en(dig_valid[idx_nx]), .seg(seg));

  // truncating the concatenation drops the oldest digit on each shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      dig_valid <= '0;
      ref_cnt <= '0;
      idx <= '0;
      anode <= ~DIGITS'(1);
      cathode <= 8'hFF;
    end else begin
      if (fire) begin
        digits <= BW'({digits, sweep_now.code});
        dig_valid <= DIGITS'({dig_valid, 1'b1});
      end
      if (clr) dig_valid <= '0;
      ref_cnt <= ref_end ? '0 : ref_cnt + 1'b1;
      idx <= idx_nx;
      anode <= ~(DIGITS'(1) << idx_nx);
      cathode <= seg;
    end
  end
endmodule

// File: tb/tb_keypad_scan_display.sv
// tb_keypad_scan_display: randomized keypad stimulus with a sweep-level reference model and scoreboard monitor
module tb_keypad_scan_display;
  localparam int SD = 4, DB = 3, RD = 8, ND = 4, SWP = 4 * SD;
  typedef struct {int code; int cyc;} ev_t;

  logic clk = 0, rst_n = 0, clr = 0, clr_q = 0;
  logic [3:0] row_n, col_n, key_code, anode;
  logic key_valid;
  logic [7:0] cathode;
  logic [15:0] keys = '0;
  int checks = 0, errors = 0, cyc = 0, sw = 0, reported = -1, ev_seen = 0, e0;
  bit run = 0;
  int hist[$];
  ev_t exp_q[$];
  int mbuf[ND];
  bit mval[ND];
  int kmap[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};
  int glyph[16] = '{'hC0, 'hF9, 'hA4, 'hB0, 'h99, 'h92, 'h82, 'hF8,
                    'h80, 'h90, 'h88, 'h83, 'hC6, 'hA1, 'h86, 'h8E};
  int ov[5] = '{1, 2, 3, 10, 7};

  keypad_scan_display #(.DIGITS(ND), .SCAN_DIV(SD), .DEBOUNCE_SWEEPS(DB), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .clr(clr),
    .key_valid(key_valid), .key_code(key_code), .anode(anode), .cathode(cathode)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk) clr_q <= clr;

  always @(negedge clk) if (key_valid) ev_seen++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_key(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) return kmap[r][c];
    return -1;
  endfunction

  function automatic logic [15:0] kb(input int code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kmap[r][c] == code) return 16'(1) << (r * 4 + c);
    return '0;
  endfunction

  // one full sweep with constant keys; the model predicts any event due at its end
  task automatic sweep(input logic [15:0] k, input bit clr_end = 0);
    int res;
    bit stable;
    keys = k;
    res = first_key(k);
    hist.push_back(res);
    if (hist.size() > DB) void'(hist.pop_front());
    stable = hist.size() == DB;
    foreach (hist[i]) if (hist[i] != res) stable = 0;
    if (stable) begin
      if (res >= 0 && res != reported) exp_q.push_back(ev_t'{res, SWP * (sw + 1)});
      reported = res;
    end
    sw++;
    repeat (SWP - 1) @(negedge clk);
    clr = clr_end;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    repeat (n) sweep(k);
  endtask

  task automatic watch_digits(input logic [31:0] ex);
    repeat (2 * SWP) begin
      @(negedge clk);
      for (int i = 0; i < ND; i++)
        if (!anode[i]) chk($sformatf("digit%0d", i), cathode, ex[i*8 +: 8]);
    end
  endtask

  // the cathode seen now was built from the buffer before this edge, so compare first, then apply the edge
  always @(negedge clk) if (run) begin
    int idx;
    logic [3:0] ea;
    logic [7:0] ec;
    ev_t e;
    idx = (cyc / RD) % ND;
    ea = ~(4'b0001 << idx);
    ec = mval[idx] ? 8'(glyph[mbuf[idx]]) : 8'hFF;
    chk("anode", anode, ea);
    chk("cathode", cathode, ec);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("key_valid", key_valid, 1);
      chk("key_code", key_code, e.code);
      for (int i = ND - 1; i > 0; i--) begin
        mbuf[i] = mbuf[i-1];
        mval[i] = mval[i-1];
      end
      mbuf[0] = e.code;
      mval[0] = 1;
    end else chk("key_valid", key_valid, 0);
    if (clr_q) for (int i = 0; i < ND; i++) mval[i] = 0;
  end

  initial begin
    for (int i = 0; i < ND; i++) begin
      mbuf[i] = 0;
      mval[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_col_n", col_n, 4'hE);
    chk("rst_anode", anode, 4'hE);
    chk("rst_cathode", cathode, 8'hFF);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    rst_n = 1;
    keys = kb(5);
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_col_n", col_n, 4'hE);
    chk("midrst_anode", anode, 4'hE);
    chk("midrst_cathode", cathode, 8'hFF);
    chk("midrst_key_valid", key_valid, 0);
    keys = '0;
    @(negedge clk);
    rst_n = 1;
    run = 1;
    e0 = ev_seen;
    hold(kb(5), 10);
    chk("held_events", ev_seen - e0, 1);
    chk("held_code", key_code, 5);
    e0 = ev_seen;
    for (int i = 0; i < 12; i++) sweep(i % 2 ? kb(5) : 16'h0);
    chk("bounce_events", ev_seen - e0, 0);
    e0 = ev_seen;
    foreach (ov[i]) begin
      hold(kb(ov[i]), 4);
      hold('0, 4);
    end
    chk("overflow_events", ev_seen - e0, 5);
    fork
      hold('0, 2);
      watch_digits({8'hA4, 8'hB0, 8'h88, 8'hF8});
    join
    e0 = ev_seen;
    hold(kb(3), 4);
    hold(kb(13), 4);
    hold('0, 4);
    chk("roll_events", ev_seen - e0, 2);
    chk("roll_code", key_code, 13);
    e0 = ev_seen;
    hold(kb(1) | kb(0), 4);
    hold('0, 4);
    chk("priority_events", ev_seen - e0, 1);
    chk("priority_code", key_code, 1);
    e0 = ev_seen;
    sweep(kb(12));
    sweep(kb(12));
    sweep(kb(12), 1);
    sweep(kb(12));
    hold('0, 4);
    chk("clr_events", ev_seen - e0, 1);
    chk("clr_code", key_code, 12);
    fork
      hold('0, 2);
      watch_digits(32'hFFFF_FFFF);
    join
    repeat (40) begin
      logic [15:0] k;
      int sel;
      sel = $urandom_range(0, 3);
      k = sel == 0 ? 16'h0 :
          sel == 3 ? (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15)) :
          16'(1) << $urandom_range(0, 15);
      hold(k, $urandom_range(1, 5));
    end
    hold('0, 4);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
